qsn_controller_pipe: RTL and testbench
======================================

Name: qsn_controller_pipe

Overview:
Parametrised, pipelined successor to the fixed length-15 QSN controller. It turns a stream of circulant shift factors into left_sel/right_sel/merge_sel for a QSN barrel shifter of any PERMUTATION_LENGTH. It adds a relative-shift mode for layered decoding, where the applied shift is the delta from the previous layer's offset. It also adds valid/ready flow control and a two-stage pipeline. It sits between the layer scheduler (shift ROM) and the qsn_bs datapath.

Parameters:
PERMUTATION_LENGTH, 15, circulant size L (L >= 2)
SHIFT_W, $clog2(PERMUTATION_LENGTH), width of shift and select fields
RELATIVE_MODE, 1, 1 = apply delta (target - current offset) mod L; 0 = apply shift_factor directly

Ports:
sys_clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  shift_factor valid
in_ready  output  1  block can accept shift_factor
shift_factor  input  SHIFT_W  target circulant offset
layer_start  input  1  sampled with an accepted input; forces current offset to 0 before the delta is computed
out_valid  output  1  select outputs valid
out_ready  input  1  downstream shifter accepts selects
left_sel  output  SHIFT_W  left-shift amount
right_sel  output  SHIFT_W  right-shift amount
merge_sel  output  L-1  per-lane merge mux select
cur_offset  output  SHIFT_W  offset held after the last accepted input
range_err  output  1  sticky: an out-of-range shift_factor was seen

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - out_valid, left_sel, right_sel, merge_sel, cur_offset, range_err, and both stage-valid flags all go to 0.
  - in_ready is 1 from the first cycle after rst deasserts.
  - Reset mid-operation flushes both stages without emitting output.
- Handshake:
  - A transfer occurs on a cycle with in_valid & in_ready, or out_valid & out_ready.
  - in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready.
  - Full throughput of one shift per cycle while out_ready = 1.
  - Outputs are held stable while out_valid & !out_ready.
- Stage 1 (on input accept):
  - base = layer_start ? 0 : cur_offset.
  - t = shift_factor, reduced into [0, L-1] (see Optional Feature).
  - eff = RELATIVE_MODE ? (t - base) mod L, computed as t >= base ? t - base : t + L - base; otherwise eff = t.
  - cur_offset <= t on every accept, in both modes.
- Stage 2 (decode registered from stage 1):
  - s = eff.
  - left_sel = s.
  - right_sel = (s == 0) ? 0 : L - s.
  - merge_sel[i] = 1 for i < L - s, else 0, only when s != 0; merge_sel = 0 when s == 0.
  - Examples for L=15: s=1 gives all 14 bits set; s=14 gives only bit 0 set.
- Latency: 2 cycles from input accept to out_valid with no backpressure.
- Back-to-back inputs: the delta chain uses the t of the immediately preceding accepted input, even if that input is still in flight.
- Simultaneous reset and transfer: reset wins; no state update.
- No accept with in_valid=0: layer_start is ignored.

Optional Feature:
Macro QSN_CTRL_RANGE_CHK_EN.
- Defined:
  - shift_factor >= L on an accepted input sets range_err (sticky until rst).
  - That input's t is forced to 0 and cur_offset becomes 0.
- Undefined:
  - range_err is tied 0.
  - An out-of-range value is reduced by a single subtraction, t = shift_factor - L. This is valid because 2^SHIFT_W - 1 < 2L.
  - Example, L=15: shift_factor 15 gives t=0.

Test Plan:
- Reset, then absolute mode (RELATIVE_MODE=0), L=15, shift 5 with out_ready=1 -> 2 cycles later: left_sel=5, right_sel=10, merge_sel=14'b00001111111111.
- Relative mode, L=15:
  - Inputs 4 (layer_start=1), then 9, then 2 -> effective 4, 5, 8.
  - Selects for those: left_sel 4/5/8, right_sel 11/10/7, merge_sel ones-count 11/10/7.
  - cur_offset ends at 2.
- Shift 0, and relative repeat of the same offset (7 then 7) -> second output s=0: left_sel=0, right_sel=0, merge_sel=0.
- Backpressure: stream 1,2,3,4 with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - Outputs hold the first value.
  - After release, all 4 emerge in order with no loss or duplication.
- Out-of-range: shift_factor=15, L=15:
  - With QSN_CTRL_RANGE_CHK_EN -> range_err=1, s=0, cur_offset=0.
  - Without it -> range_err=0, s=0.
- Assert rst while 2 transfers are in flight -> next cycle out_valid=0 and cur_offset=0. Next input 6 in relative mode -> s=6.

Source files
------------

// File: rtl/qsn_controller_pipe.sv
// Two-stage QSN barrel-shifter select generator with valid/ready flow control and optional relative-shift mode.
// Define QSN_CTRL_RANGE_CHK_EN to flag out-of-range shift factors (sticky range_err) instead of folding them.
module qsn_controller_pipe #(
  parameter int PERMUTATION_LENGTH = 15,
  parameter int SHIFT_W            = $clog2(PERMUTATION_LENGTH),
  parameter int RELATIVE_MODE      = 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SHIFT_W-1:0]            shift_factor,
  input  logic                          layer_start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SHIFT_W-1:0]            left_sel,
  output logic [SHIFT_W-1:0]            right_sel,
  output logic [PERMUTATION_LENGTH-2:0] merge_sel,
  output logic [SHIFT_W-1:0]            cur_offset,
  output logic                          range_err
);

  localparam logic [SHIFT_W:0] LEN = (SHIFT_W+1)'(PERMUTATION_LENGTH);

  logic                          s1_valid_q, s1_valid_d;
  logic [SHIFT_W-1:0]            s1_eff_q, s1_eff_d;
  logic [SHIFT_W-1:0]            offset_q, offset_d;
  logic                          s2_valid_q, s2_valid_d;
  logic [SHIFT_W-1:0]            left_q, left_d;
  logic [SHIFT_W-1:0]            right_q, right_d;
  logic [PERMUTATION_LENGTH-2:0] merge_q, merge_d;

  logic                          s1_advance;
  logic                          in_accept;
  logic                          oor;
  logic [SHIFT_W:0]              sf_ext;
  logic [SHIFT_W:0]              t_ext;
  logic [SHIFT_W:0]              base_ext;
  logic [SHIFT_W-1:0]            eff;
  logic [SHIFT_W-1:0]            dec_right;
  logic [PERMUTATION_LENGTH-2:0] dec_merge;

  // Stage 1: reduce the target offset and form the applied shift
  always_comb begin
    s1_advance = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_advance;
    in_accept  = in_valid && in_ready;
    sf_ext     = {1'b0, shift_factor};
    oor        = (sf_ext >= LEN);
`ifdef QSN_CTRL_RANGE_CHK_EN
    t_ext      = oor ? '0 : sf_ext;
`else
    t_ext      = oor ? (sf_ext - LEN) : sf_ext;
`endif
    base_ext   = layer_start ? '0 : {1'b0, offset_q};
    if (RELATIVE_MODE != 0) begin
      eff = (t_ext >= base_ext) ? SHIFT_W'(t_ext - base_ext)
                                : SHIFT_W'(t_ext + LEN - base_ext);
    end else begin
      eff = t_ext[SHIFT_W-1:0];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_eff_d   = s1_eff_q;
    offset_d   = offset_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_eff_d   = eff;
      offset_d   = t_ext[SHIFT_W-1:0];
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: right_sel is zero for s == 0, which also clears every merge lane
  always_comb begin
    dec_right = (s1_eff_q == '0) ? '0 : SHIFT_W'(LEN - {1'b0, s1_eff_q});
    dec_merge = '0;
    for (int unsigned i = 0; i < PERMUTATION_LENGTH - 1; i++) begin
      dec_merge[i] = ((SHIFT_W+1)'(i) < {1'b0, dec_right});
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    left_d     = left_q;
    right_d    = right_q;
    merge_d    = merge_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        left_d  = s1_eff_q;
        right_d = dec_right;
        merge_d = dec_merge;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_eff_q   <= '0;
      offset_q   <= '0;
      s2_valid_q <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      merge_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_eff_q   <= s1_eff_d;
      offset_q   <= offset_d;
      s2_valid_q <= s2_valid_d;
      left_q     <= left_d;
      right_q    <= right_d;
      merge_q    <= merge_d;
    end
  end

`ifdef QSN_CTRL_RANGE_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (in_accept && oor);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign range_err = err_q;
`else
  assign range_err = 1'b0;
`endif

  assign out_valid  = s2_valid_q;
  assign left_sel   = left_q;
  assign right_sel  = right_q;
  assign merge_sel  = merge_q;
  assign cur_offset = offset_q;

endmodule

// File: tb/tb_qsn_controller_pipe.sv
// Bench for qsn_controller_pipe: relative and absolute instances share one input stream, checked against a queue model.
module tb_qsn_controller_pipe;
  localparam int L = 15;
`ifdef QSN_CTRL_RANGE_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        layer_start = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  shift_factor = '0;

  logic        r_in_ready, r_out_valid, r_err;
  logic [3:0]  r_left, r_right, r_cur;
  logic [13:0] r_merge;
  logic        a_in_ready, a_out_valid, a_err;
  logic [3:0]  a_left, a_right, a_cur;
  logic [13:0] a_merge;

  qsn_controller_pipe #(.PERMUTATION_LENGTH(L), .RELATIVE_MODE(1)) dut_rel (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
    .shift_factor(shift_factor), .layer_start(layer_start), .out_valid(r_out_valid),
    .out_ready(out_ready), .left_sel(r_left), .right_sel(r_right), .merge_sel(r_merge),
    .cur_offset(r_cur), .range_err(r_err));

  qsn_controller_pipe #(.PERMUTATION_LENGTH(L), .RELATIVE_MODE(0)) dut_abs (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .shift_factor(shift_factor), .layer_start(layer_start), .out_valid(a_out_valid),
    .out_ready(out_ready), .left_sel(a_left), .right_sel(a_right), .merge_sel(a_merge),
    .cur_offset(a_cur), .range_err(a_err));

  always #5 sys_clk = ~sys_clk;

  int ntests = 0;
  int nfail  = 0;
  int q_rel[$];
  int q_abs[$];
  int m_off = 0;
  bit m_err = 1'b0;
  bit acc_last = 1'b0;
  int pops = 0;
  int last_rl, last_rr, last_rm, last_al;

  typedef struct {
    bit ls;
    int sf;
    int rel_left;
    int rel_right;
    int rel_merge;
    int abs_left;
    int cur;
    bit err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int merge_of(input int s);
    return (s == 0) ? 0 : ((1 << (L - s)) - 1);
  endfunction

  function automatic int right_of(input int s);
    return (s == 0) ? 0 : (L - s);
  endfunction

  function automatic int t_of(input int sf);
    if (sf < L) return sf;
    return ERR_EN ? 0 : (sf - L);
  endfunction

  task automatic cycle(input bit v, input int sf, input bit ls, input bit ordy, output bit acc);
    int n, s, t, base;
    @(negedge sys_clk);
    in_valid = v; shift_factor = 4'(sf); layer_start = ls; out_ready = ordy;
    #1;
    n = q_rel.size();
    chk("rel_in_ready", r_in_ready, (n < 2 || ordy) ? 1 : 0);
    chk("abs_in_ready", a_in_ready, (n < 2 || ordy) ? 1 : 0);
    chk("rel_out_valid", r_out_valid, (n >= 2 || (n == 1 && !acc_last)) ? 1 : 0);
    chk("abs_out_valid", a_out_valid, (n >= 2 || (n == 1 && !acc_last)) ? 1 : 0);
    if (r_out_valid && ordy && n > 0) begin
      s = q_rel.pop_front();
      chk("rel_left", r_left, s);
      chk("rel_right", r_right, right_of(s));
      chk("rel_merge", r_merge, merge_of(s));
      s = q_abs.pop_front();
      chk("abs_left", a_left, s);
      chk("abs_right", a_right, right_of(s));
      chk("abs_merge", a_merge, merge_of(s));
      last_rl = r_left; last_rr = r_right; last_rm = r_merge; last_al = a_left;
      pops++;
    end
    acc = v && r_in_ready;
    if (acc) begin
      t    = t_of(sf);
      base = ls ? 0 : m_off;
      q_rel.push_back((t - base + L) % L);
      q_abs.push_back(t);
      m_off = t;
      if (sf >= L && ERR_EN) m_err = 1'b1;
    end
    @(posedge sys_clk);
    #1;
    acc_last = acc;
    chk("rel_cur_offset", r_cur, m_off);
    chk("abs_cur_offset", a_cur, m_off);
    chk("rel_range_err", r_err, m_err);
    chk("abs_range_err", a_err, m_err);
  endtask

  task automatic do_reset(input bit busy);
    @(negedge sys_clk);
    rst = 1'b1; in_valid = busy; shift_factor = 4'd9; layer_start = 1'b0; out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("rst_rel_out_valid", r_out_valid, 0);
    chk("rst_abs_out_valid", a_out_valid, 0);
    chk("rst_cur_offset", r_cur, 0);
    chk("rst_range_err", r_err, 0);
    chk("rst_left", r_left, 0);
    chk("rst_right", r_right, 0);
    chk("rst_merge", r_merge, 0);
    q_rel.delete(); q_abs.delete();
    m_off = 0; m_err = 1'b0; acc_last = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", r_in_ready, 1);
  endtask

  initial begin
    vec_t tbl[10];
    bit acc;
    int p0, idx;

    tbl[0] = '{ls: 1, sf: 5,  rel_left: 5,  rel_right: 10, rel_merge: 14'h03FF, abs_left: 5,  cur: 5,  err: 0};
    tbl[1] = '{ls: 1, sf: 4,  rel_left: 4,  rel_right: 11, rel_merge: 14'h07FF, abs_left: 4,  cur: 4,  err: 0};
    tbl[2] = '{ls: 0, sf: 9,  rel_left: 5,  rel_right: 10, rel_merge: 14'h03FF, abs_left: 9,  cur: 9,  err: 0};
    tbl[3] = '{ls: 0, sf: 2,  rel_left: 8,  rel_right: 7,  rel_merge: 14'h007F, abs_left: 2,  cur: 2,  err: 0};
    tbl[4] = '{ls: 0, sf: 0,  rel_left: 13, rel_right: 2,  rel_merge: 14'h0003, abs_left: 0,  cur: 0,  err: 0};
    tbl[5] = '{ls: 1, sf: 7,  rel_left: 7,  rel_right: 8,  rel_merge: 14'h00FF, abs_left: 7,  cur: 7,  err: 0};
    tbl[6] = '{ls: 0, sf: 7,  rel_left: 0,  rel_right: 0,  rel_merge: 14'h0000, abs_left: 7,  cur: 7,  err: 0};
    tbl[7] = '{ls: 0, sf: 14, rel_left: 7,  rel_right: 8,  rel_merge: 14'h00FF, abs_left: 14, cur: 14, err: 0};
    tbl[8] = '{ls: 1, sf: 15, rel_left: 0,  rel_right: 0,  rel_merge: 14'h0000, abs_left: 0,  cur: 0,  err: 1};
    tbl[9] = '{ls: 0, sf: 1,  rel_left: 1,  rel_right: 14, rel_merge: 14'h3FFF, abs_left: 1,  cur: 1,  err: 1};

    do_reset(1'b0);

    // Single transactions, two-cycle latency, chained offsets
    for (int i = 0; i < 10; i++) begin
      p0 = pops;
      cycle(1'b1, tbl[i].sf, tbl[i].ls, 1'b1, acc);
      chk("tbl_accept", acc, 1);
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
      chk("tbl_emitted", pops - p0, 1);
      chk("tbl_rel_left", last_rl, tbl[i].rel_left);
      chk("tbl_rel_right", last_rr, tbl[i].rel_right);
      chk("tbl_rel_merge", last_rm, tbl[i].rel_merge);
      chk("tbl_abs_left", last_al, tbl[i].abs_left);
      chk("tbl_cur_offset", r_cur, tbl[i].cur);
      chk("tbl_range_err", r_err, tbl[i].err & ERR_EN);
    end

    // Backpressure: two accepts fill the pipe, outputs hold, then all four drain in order
    do_reset(1'b0);
    p0 = pops;
    cycle(1'b1, 1, 1'b1, 1'b0, acc);
    chk("bp_acc1", acc, 1);
    cycle(1'b1, 2, 1'b0, 1'b0, acc);
    chk("bp_acc2", acc, 1);
    cycle(1'b1, 3, 1'b0, 1'b0, acc);
    chk("bp_stall", acc, 0);
    chk("bp_hold_left", r_left, 1);
    chk("bp_hold_abs_left", a_left, 1);
    idx = 2;
    for (int k = 0; k < 20; k++) begin
      if (idx >= 4 && q_rel.size() == 0) break;
      cycle(idx < 4, idx + 1, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_emitted", pops - p0, 4);

    // Reset with two transfers in flight
    cycle(1'b1, 3, 1'b1, 1'b1, acc);
    cycle(1'b1, 8, 1'b0, 1'b1, acc);
    do_reset(1'b1);
    p0 = pops;
    cycle(1'b1, 6, 1'b0, 1'b1, acc);
    cycle(1'b0, 0, 1'b0, 1'b1, acc);
    cycle(1'b0, 0, 1'b0, 1'b1, acc);
    chk("post_rst_emitted", pops - p0, 1);
    chk("post_rst_s", last_rl, 6);

    // Randomised traffic against the queue model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) < 7, acc);
      end
    end
    for (int k = 0; k < 20; k++) begin
      if (q_rel.size() == 0) break;
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
    end
    chk("drain_empty", q_rel.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
